// File: rtl/pu_msp430_pkg.sv
// Shared definitions for the MSP430 reset controller: FSM states and
// rst_cause bit positions.
package pu_msp430_pkg;

   typedef enum logic [1:0] {
      POR_HOLD = 2'd0,
      PUC_HOLD = 2'd1,
      RUN      = 2'd2
   } rst_state_t;

   localparam int unsigned CAUSE_POR = 0;
   localparam int unsigned CAUSE_EXT = 1;
   localparam int unsigned CAUSE_WDT = 2;
   localparam int unsigned CAUSE_DBG = 3;

endpackage

// File: rtl/pu_msp430_reset_ctrl.sv
// Reset sequencer: holds POR until all POR sources release, then a fixed
// PUC-only window, then RUN. Records sticky reset causes.
module pu_msp430_reset_ctrl
   import pu_msp430_pkg::*;
#(
   parameter int unsigned POR_CYCLES = 16,
   parameter int unsigned PUC_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ext_rst_req,
   input  logic       wdt_rst_req,
   input  logic       dbg_rst_req,
   input  logic       cause_clr,
   output logic       por_o,
   output logic       puc_o,
   output logic       rst_busy,
   output logic [3:0] rst_cause
);

   localparam int unsigned MAX_CYCLES = (POR_CYCLES > PUC_CYCLES) ? POR_CYCLES : PUC_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES);
   localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
   localparam logic [CNT_W-1:0] PUC_LAST = CNT_W'(PUC_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   rst_state_t       state_r;
   rst_state_t       state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic [3:0]       cause_set_s;
   logic [3:0]       cause_s;
   logic             soft_req_s;

   // Next-state, counter and cause computation
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      cause_set_s = 4'b0000;
      soft_req_s  = wdt_rst_req | dbg_rst_req;

      case (state_r)
         POR_HOLD: begin
            // watchdog/debug requests cannot shorten or extend a POR
            if (ext_rst_req) begin
               cnt_s = CNT_ZERO;
            end else if (cnt_r == POR_LAST) begin
               state_s = PUC_HOLD;
               cnt_s   = CNT_ZERO;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         PUC_HOLD: begin
            if (ext_rst_req) begin
               state_s = POR_HOLD;
               cnt_s   = CNT_ZERO;
            end else if (soft_req_s) begin
               cnt_s = CNT_ZERO;
            end else if (cnt_r == PUC_LAST) begin
               state_s = RUN;
               cnt_s   = CNT_ZERO;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         RUN: begin
            if (ext_rst_req) begin
               state_s = POR_HOLD;
               cnt_s   = CNT_ZERO;
            end else if (soft_req_s) begin
               state_s = PUC_HOLD;
               cnt_s   = CNT_ZERO;
            end else begin
               cnt_s = CNT_ZERO;
            end
         end
         default: begin
            state_s = POR_HOLD;
            cnt_s   = CNT_ZERO;
         end
      endcase

      cause_set_s[CAUSE_EXT] = ext_rst_req;
      cause_set_s[CAUSE_WDT] = wdt_rst_req;
      cause_set_s[CAUSE_DBG] = dbg_rst_req;
      // a cause raised in the same cycle as a clear survives it
      if (cause_clr) begin
         cause_s = cause_set_s;
      end else begin
         cause_s = rst_cause | cause_set_s;
      end
   end

   // State, counter and registered outputs (outputs track the state register)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= POR_HOLD;
         cnt_r     <= CNT_ZERO;
         por_o     <= 1'b1;
         puc_o     <= 1'b1;
         rst_busy  <= 1'b1;
         rst_cause <= 4'b0001;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         por_o     <= (state_s == POR_HOLD);
         puc_o     <= (state_s != RUN);
         rst_busy  <= (state_s != RUN);
         rst_cause <= cause_s;
      end
   end

endmodule

// File: tb/tb_pu_msp430_reset_ctrl.sv
// Scoreboard bench for pu_msp430_reset_ctrl: directed reset scenarios plus
// random requests, checked against a window-based reference model.
module tb_pu_msp430_reset_ctrl;

   localparam int POR_N = 16;
   localparam int PUC_N = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ext_rst_req = 1'b0;
   logic       wdt_rst_req = 1'b0;
   logic       dbg_rst_req = 1'b0;
   logic       cause_clr = 1'b0;
   logic       por_o;
   logic       puc_o;
   logic       rst_busy;
   logic [3:0] rst_cause;

   int total = 0;
   int bad   = 0;

   logic [6:0] exp_q[$];

   // reference model: mode 0 = power-on hold, 1 = puc-only window, 2 = running
   int         m_mode     = 0;
   int         m_quiet    = 0;
   int         m_puc_left = 0;
   logic [3:0] m_cause    = 4'b0001;

   pu_msp430_reset_ctrl #(.POR_CYCLES(POR_N), .PUC_CYCLES(PUC_N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ext_rst_req (ext_rst_req),
      .wdt_rst_req (wdt_rst_req),
      .dbg_rst_req (dbg_rst_req),
      .cause_clr   (cause_clr),
      .por_o       (por_o),
      .puc_o       (puc_o),
      .rst_busy    (rst_busy),
      .rst_cause   (rst_cause)
   );

   always #5 clk = ~clk;

   task automatic model_edge(input logic r, input logic e, input logic w, input logic d, input logic c);
      if (!r) begin
         m_mode  = 0;
         m_quiet = 0;
         m_cause = 4'b0001;
      end else begin
         m_cause = (c ? 4'b0000 : m_cause) | {d, w, e, 1'b0};
         if (e) begin
            m_mode  = 0;
            m_quiet = 0;
         end else if (m_mode == 0) begin
            m_quiet = m_quiet + 1;
            if (m_quiet == POR_N) begin
               m_mode     = 1;
               m_puc_left = PUC_N;
            end
         end else if (w || d) begin
            m_mode     = 1;
            m_puc_left = PUC_N;
         end else if (m_mode == 1) begin
            m_puc_left = m_puc_left - 1;
            if (m_puc_left == 0) m_mode = 2;
         end
      end
   endtask

   task automatic step(input logic r, input logic e, input logic w, input logic d, input logic c);
      logic xp_por;
      logic xp_puc;
      @(negedge clk);
      rst_n       = r;
      ext_rst_req = e;
      wdt_rst_req = w;
      dbg_rst_req = d;
      cause_clr   = c;
      model_edge(r, e, w, d, c);
      xp_por = (m_mode == 0);
      xp_puc = (m_mode != 2);
      exp_q.push_back({xp_por, xp_puc, xp_puc, m_cause});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // monitor: compare DUT outputs after every edge with the queued expectation
   initial begin
      logic [6:0] e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (por_o !== e[6]) begin
               bad++;
               $display("FAIL por_o t=%0t got=%b want=%b", $time, por_o, e[6]);
            end
            total++;
            if (puc_o !== e[5]) begin
               bad++;
               $display("FAIL puc_o t=%0t got=%b want=%b", $time, puc_o, e[5]);
            end
            total++;
            if (rst_busy !== e[4]) begin
               bad++;
               $display("FAIL rst_busy t=%0t got=%b want=%b", $time, rst_busy, e[4]);
            end
            total++;
            if (rst_cause !== e[3:0]) begin
               bad++;
               $display("FAIL rst_cause t=%0t got=%b want=%b", $time, rst_cause, e[3:0]);
            end
         end
      end
   end

   initial begin
      int ext_burst;
      logic e;
      int waited;
      ext_burst = 0;

      // power-on: reset 3 cycles, then full POR + PUC sequence
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(30);
      // watchdog pulse in RUN
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(12);
      // debug pulse while PUC counter is at 5
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(5);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(12);
      // external request held 20 cycles
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(30);
      // clear and watchdog together with cause = 0001
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(26);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      idle(4);
      // reset in the middle of the PUC window
      idle(10);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(30);
      // cause clear in RUN, and wdt/dbg ignored during POR
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(30);

      for (int i = 0; i < 2000; i++) begin
         if (ext_burst > 0) begin
            e = 1'b1;
            ext_burst--;
         end else begin
            e = 1'b0;
            if ($urandom_range(0, 99) == 0) ext_burst = int'($urandom_range(1, 25));
         end
         step(($urandom_range(0, 199) != 0),
              e,
              ($urandom_range(0, 29) == 0),
              ($urandom_range(0, 29) == 0),
              ($urandom_range(0, 19) == 0));
      end
      idle(2);

      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
         @(posedge clk);
         waited++;
      end
      #3;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pu_msp430_reset_ctrl.md
PU_MSP430_RESET_CTRL -- requirements
Module: pu_msp430_reset_ctrl

Interface
REQ-001 SHALL have parameter POR_CYCLES, default 16: minimum por_o hold length after all POR sources release; legal values 2..65535.
REQ-002 SHALL have parameter PUC_CYCLES, default 8: exact puc_o-only hold length; legal values 2..65535.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port ext_rst_req, input, 1: external reset request; level, active-high, already synchronous to clk.
REQ-006 SHALL have port wdt_rst_req, input, 1: watchdog reset request; single-cycle pulse.
REQ-007 SHALL have port dbg_rst_req, input, 1: debug-interface reset request; single-cycle pulse.
REQ-008 SHALL have port cause_clr, input, 1: single-cycle pulse that clears rst_cause.
REQ-009 SHALL have port por_o, output, 1: power-on reset, active-high.
REQ-010 SHALL have port puc_o, output, 1: power-up clear, active-high; asserted whenever por_o is asserted.
REQ-011 SHALL have port rst_busy, output, 1: high in any state other than RUN.
REQ-012 SHALL have port rst_cause, output, 4: sticky one-hot-per-source flags, bit order {dbg, wdt, ext, por}.

Function
REQ-013 SHALL implement a 3-state FSM: POR_HOLD, PUC_HOLD, RUN.
REQ-014 SHALL register all outputs; outputs SHALL be decoded from the current state only:
- POR_HOLD: por_o=1, puc_o=1, rst_busy=1.
- PUC_HOLD: por_o=0, puc_o=1, rst_busy=1.
- RUN: all three = 0.
REQ-015 SHALL, in POR_HOLD, hold cnt at 0 while ext_rst_req=1, and otherwise increment cnt by one per cycle.
REQ-016 SHALL, in POR_HOLD, move to PUC_HOLD with cnt=0 when cnt==POR_CYCLES-1 and ext_rst_req=0.
REQ-017 SHALL, in PUC_HOLD, increment cnt each cycle and move to RUN when cnt==PUC_CYCLES-1.
REQ-018 SHALL, in PUC_HOLD or RUN, go to POR_HOLD with cnt=0 on ext_rst_req=1; this has priority over wdt_rst_req and dbg_rst_req.
REQ-019 SHALL, in RUN, go to PUC_HOLD with cnt=0 on wdt_rst_req or dbg_rst_req.
REQ-020 SHALL, in PUC_HOLD, restart cnt at 0 on wdt_rst_req or dbg_rst_req; the puc_o window is re-extended by the full PUC_CYCLES.
REQ-021 SHALL ignore wdt_rst_req and dbg_rst_req in POR_HOLD for state and count, but SHALL still record them in rst_cause.
REQ-022 SHALL set rst_cause bits as follows:
- ext bit on any cycle with ext_rst_req=1.
- wdt bit on wdt_rst_req.
- dbg bit on dbg_rst_req.
- Simultaneous requests set all corresponding bits.
REQ-023 SHALL clear rst_cause to 0 on cause_clr, except that a bit set in the same cycle SHALL win over the clear.
REQ-024 SHALL assert puc_o for exactly PUC_CYCLES cycles after a request seen at edge N in RUN, starting with the cycle after edge N (one-cycle latency).
REQ-025 SHALL size cnt to $clog2(max(POR_CYCLES, PUC_CYCLES)) bits; cnt SHALL never wrap.

Reset
REQ-026 SHALL, when rst_n=0 at a clk edge, load state=POR_HOLD, cnt=0, por_o=1, puc_o=1, rst_busy=1, rst_cause=4'b0001.
REQ-027 SHALL make reset mid-sequence (any state) abort the sequence and apply the values of REQ-026; por_o stays high for POR_CYCLES cycles after rst_n returns high.

Structure
REQ-028 SHALL place the FSM state enum and the rst_cause bit-index constants in shared package pu_msp430_pkg.
REQ-029 SHALL be a single module with no sub-modules; consumers in other clock domains SHALL resynchronize por_o and puc_o themselves.

Verification
REQ-030 SHALL check: rst_n low 3 cycles, then high, no requests -> por_o high 16 cycles after release, then puc_o-only 8 cycles, then RUN; rst_cause=0001.
REQ-031 SHALL check: in RUN, wdt_rst_req pulse at edge N -> puc_o=1 over cycles N+1..N+8, por_o=0 throughout, rst_cause wdt bit=1.
REQ-032 SHALL check: in PUC_HOLD at cnt=5, dbg_rst_req pulse -> puc_o held 8 further cycles, rst_cause dbg bit=1.
REQ-033 SHALL check: ext_rst_req high for 20 cycles in RUN -> POR_HOLD; por_o high for 20 + 16 cycles before PUC_HOLD.
REQ-034 SHALL check: wdt_rst_req and cause_clr in the same cycle with rst_cause=0001 -> rst_cause=0100.
REQ-035 SHALL check: rst_n asserted at PUC_HOLD cnt=3 -> next cycle por_o=1, rst_cause=0001, and the full sequence restarts.
